vip_target_bbox_locator: RTL

- Consumes the final binary mask (dilated Sobel edge image) at the tail of the vip pipeline.
- Computes per frame the foreground bounding box, its centre and the foreground pixel count.
- Latches the results at end of frame for the game/CPU side to read as a stable target position.
- Sits directly downstream of the dilation stage; the mask stream terminates here.

---
 rtl/vip_target_pkg.sv | 18 +
 rtl/vip_frame_pos_counter.sv | 56 +++++
 rtl/vip_target_bbox_locator.sv | 116 +++++++++++
 3 files changed

// File: rtl/vip_target_pkg.sv
// rtl/vip_target_pkg.sv - shared widths, image geometry defaults and helpers for the target locator
package vip_target_pkg;
  localparam int CW          = 11;
  localparam int PCW         = 20;
  localparam int IMG_H_DEF   = 640;
  localparam int IMG_V_DEF   = 480;
  localparam int MIN_PIX_DEF = 16;

  localparam logic [CW-1:0] MIN_INIT   = '1;
  localparam logic [CW-1:0] COORD_ZERO = '0;

  // Midpoint taken at CW+1 bits so min+max can never wrap.
  function automatic logic [CW-1:0] coord_mid(input logic [CW-1:0] a, input logic [CW-1:0] b);
    logic [CW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CW:1];
  endfunction
endpackage

// File: rtl/vip_frame_pos_counter.sv
// rtl/vip_frame_pos_counter.sv - sync edge detection and per-pixel x/y position tracking
module vip_frame_pos_counter
  import vip_target_pkg::*;
#(
  parameter int IMG_H = IMG_H_DEF,
  parameter int IMG_V = IMG_V_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          href,
  input  logic          clken,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          vs_rise,
  output logic          vs_fall,
  output logic          pix_en
);
  logic          vs_d;
  logic          hr_d;
  logic          hr_fall;
  logic [CW-1:0] x_q;
  logic [CW-1:0] y_q;

  assign vs_rise = vsync & ~vs_d;
  assign vs_fall = ~vsync & vs_d;
  assign hr_fall = ~href & hr_d;

  // The pixel arriving with vs_rise is at the origin of the new frame.
  assign x      = vs_rise ? COORD_ZERO : x_q;
  assign y      = vs_rise ? COORD_ZERO : y_q;
  assign pix_en = clken & vsync & (x < CW'(IMG_H)) & (y < CW'(IMG_V));

  // vs_d resets high so a reset released mid-frame never looks like a frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= 1'b1;
      hr_d <= 1'b0;
      x_q  <= COORD_ZERO;
      y_q  <= COORD_ZERO;
    end else begin
      vs_d <= vsync;
      hr_d <= href;
      if (hr_fall)
        x_q <= COORD_ZERO;
      else if (clken && vsync && (x != MIN_INIT))
        x_q <= x + CW'(1);
      else
        x_q <= x;
      if (hr_fall && vsync && (y != MIN_INIT))
        y_q <= y + CW'(1);
      else
        y_q <= y;
    end
  end
endmodule

// File: rtl/vip_target_bbox_locator.sv
// rtl/vip_target_bbox_locator.sv - per-frame foreground bounding box, centre and count, latched at frame end
module vip_target_bbox_locator
  import vip_target_pkg::*;
#(
  parameter int IMG_H   = IMG_H_DEF,
  parameter int IMG_V   = IMG_V_DEF,
  parameter int MIN_PIX = MIN_PIX_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           per_frame_vsync,
  input  logic           per_frame_href,
  input  logic           per_frame_clken,
  input  logic           per_img_Bit,
  output logic           box_valid,
  output logic           target_found,
  output logic [CW-1:0]  x_min,
  output logic [CW-1:0]  x_max,
  output logic [CW-1:0]  y_min,
  output logic [CW-1:0]  y_max,
  output logic [CW-1:0]  x_ctr,
  output logic [CW-1:0]  y_ctr,
  output logic [PCW-1:0] pix_cnt
);
  logic [CW-1:0]  x, y;
  logic           vs_rise, vs_fall, pix_en;
  logic [CW-1:0]  run_xmin, run_xmax, run_ymin, run_ymax;
  logic [PCW-1:0] run_cnt;
  logic           frame_seen;
  logic [CW-1:0]  b_xmin, b_xmax, b_ymin, b_ymax;
  logic [PCW-1:0] b_cnt;
  logic [CW-1:0]  n_xmin, n_xmax, n_ymin, n_ymax;
  logic [PCW-1:0] n_cnt;
  logic           acc, latch, found;

  vip_frame_pos_counter #(.IMG_H(IMG_H), .IMG_V(IMG_V)) u_pos (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync   (per_frame_vsync),
    .href    (per_frame_href),
    .clken   (per_frame_clken),
    .x       (x),
    .y       (y),
    .vs_rise (vs_rise),
    .vs_fall (vs_fall),
    .pix_en  (pix_en)
  );

  // Compare against freshly initialised values in the vs_rise cycle so its pixel counts.
  always_comb begin
    acc    = pix_en & per_img_Bit;
    b_xmin = vs_rise ? MIN_INIT   : run_xmin;
    b_xmax = vs_rise ? COORD_ZERO : run_xmax;
    b_ymin = vs_rise ? MIN_INIT   : run_ymin;
    b_ymax = vs_rise ? COORD_ZERO : run_ymax;
    b_cnt  = vs_rise ? '0         : run_cnt;
    n_xmin = b_xmin;
    n_xmax = b_xmax;
    n_ymin = b_ymin;
    n_ymax = b_ymax;
    n_cnt  = b_cnt;
    if (acc) begin
      if (x < b_xmin) n_xmin = x;
      if (x > b_xmax) n_xmax = x;
      if (y < b_ymin) n_ymin = y;
      if (y > b_ymax) n_ymax = y;
      if (b_cnt != '1) n_cnt = b_cnt + PCW'(1);
    end
    latch = vs_fall & frame_seen;
    found = run_cnt >= PCW'(MIN_PIX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_xmin   <= MIN_INIT;
      run_xmax   <= COORD_ZERO;
      run_ymin   <= MIN_INIT;
      run_ymax   <= COORD_ZERO;
      run_cnt    <= '0;
      frame_seen <= 1'b0;
    end else begin
      run_xmin   <= n_xmin;
      run_xmax   <= n_xmax;
      run_ymin   <= n_ymin;
      run_ymax   <= n_ymax;
      run_cnt    <= n_cnt;
      frame_seen <= frame_seen | vs_rise;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      box_valid    <= 1'b0;
      target_found <= 1'b0;
      x_min        <= COORD_ZERO;
      x_max        <= COORD_ZERO;
      y_min        <= COORD_ZERO;
      y_max        <= COORD_ZERO;
      x_ctr        <= COORD_ZERO;
      y_ctr        <= COORD_ZERO;
      pix_cnt      <= '0;
    end else begin
      box_valid <= latch;
      if (latch) begin
        target_found <= found;
        pix_cnt      <= run_cnt;
        x_min        <= found ? run_xmin : COORD_ZERO;
        x_max        <= found ? run_xmax : COORD_ZERO;
        y_min        <= found ? run_ymin : COORD_ZERO;
        y_max        <= found ? run_ymax : COORD_ZERO;
        x_ctr        <= found ? coord_mid(run_xmin, run_xmax) : COORD_ZERO;
        y_ctr        <= found ? coord_mid(run_ymin, run_ymax) : COORD_ZERO;
      end
    end
  end
endmodule
